// File: rtl/pwm_3_phase_rx.sv
// Three-phase beacon receiver: synchronises pwm1..3, tracks the 1->2->3 rotation,
// measures per-phase widths and period, and reports lock and sequence/overlap/stall faults.
module pwm_3_phase_rx #(
  parameter int W        = 8,
  parameter int TIMEOUT  = 200,
  parameter int LOCK_ROT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pwm1,
  input  logic         pwm2,
  input  logic         pwm3,
  output logic [1:0]   phase,
  output logic [W-1:0] width1,
  output logic [W-1:0] width2,
  output logic [W-1:0] width3,
  output logic [W+1:0] period,
  output logic         period_valid,
  output logic         locked,
  output logic         err_seq,
  output logic         err_multi,
  output logic         err_timeout
);

  // state | meaning
  // IDLE  | not aligned; waiting for phase 1
  // P1    | phase 1 line high, counting its width
  // P2    | phase 2 line high, counting its width
  // P3    | phase 3 line high, counting its width
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_P1   = 2'd1,
    S_P2   = 2'd2,
    S_P3   = 2'd3
  } state_t;

  // Decoded codes for P1..P3 match the state codes so same/next compare directly.
  localparam logic [2:0] D_NONE  = 3'd0;
  localparam logic [2:0] D_MULTI = 3'd4;

  logic [2:0]   sync1, sync2;
  logic [2:0]   dec;
  state_t       state, state_nxt, state_adv;
  logic [W-1:0] cnt, cnt_nxt;
  logic [3:0]   good_cnt, good_nxt, good_inc;
  logic [W-1:0] width1_nxt, width2_nxt, width3_nxt;
  logic [W+1:0] period_nxt;
  logic         pv_nxt, locked_nxt, seq_nxt, multi_nxt, to_nxt;
  logic         ev_start, ev_hold, ev_adv, ev_fault, ev_seq, ev_multi, ev_to;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {pwm3, pwm2, pwm1};
      sync2 <= sync1;
    end
  end

  always_comb begin
    case (sync2)
      3'b000:  dec = D_NONE;
      3'b001:  dec = 3'd1;
      3'b010:  dec = 3'd2;
      3'b100:  dec = 3'd3;
      default: dec = D_MULTI;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_adv = (state == S_P3) ? S_P1 : state_t'(state + 2'd1);
    state_nxt = state;
    ev_start  = 1'b0;
    ev_hold   = 1'b0;
    ev_adv    = 1'b0;
    ev_fault  = 1'b0;
    ev_seq    = 1'b0;
    ev_multi  = 1'b0;
    ev_to     = 1'b0;
    if (state == S_IDLE) begin
      if (dec == 3'd1) begin
        state_nxt = S_P1;
        ev_start  = 1'b1;
      end else if (dec == D_MULTI) begin
        ev_multi = 1'b1;
      end
    end else begin
      if (dec == {1'b0, state}) begin
        if (cnt == W'(TIMEOUT)) begin
          ev_to    = 1'b1;
          ev_fault = 1'b1;
        end else begin
          ev_hold = 1'b1;
        end
      end else if (dec == {1'b0, state_adv}) begin
        ev_adv    = 1'b1;
        state_nxt = state_adv;
      end else if (dec == D_MULTI) begin
        ev_multi = 1'b1;
        ev_fault = 1'b1;
      end else if (dec == D_NONE) begin
        ev_fault = 1'b1;
      end else begin
        ev_seq   = 1'b1;
        ev_fault = 1'b1;
      end
      if (ev_fault) state_nxt = S_IDLE;
    end
  end

  always_comb begin
    cnt_nxt    = cnt;
    width1_nxt = width1;
    width2_nxt = width2;
    width3_nxt = width3;
    period_nxt = period;
    pv_nxt     = 1'b0;
    good_nxt   = good_cnt;
    locked_nxt = locked;
    seq_nxt    = ev_seq;
    multi_nxt  = ev_multi;
    to_nxt     = ev_to;
    good_inc   = (good_cnt == 4'(LOCK_ROT)) ? good_cnt : good_cnt + 4'd1;
    if (ev_start) cnt_nxt = {{(W-1){1'b0}}, 1'b1};
    if (ev_hold)  cnt_nxt = cnt + {{(W-1){1'b0}}, 1'b1};
    if (ev_adv) begin
      cnt_nxt = {{(W-1){1'b0}}, 1'b1};
      case (state)
        S_P1: width1_nxt = cnt;
        S_P2: width2_nxt = cnt;
        S_P3: begin
          width3_nxt = cnt;
          period_nxt = {2'b00, width1} + {2'b00, width2} + {2'b00, cnt};
          pv_nxt     = 1'b1;
          good_nxt   = good_inc;
          if (good_inc == 4'(LOCK_ROT)) locked_nxt = 1'b1;
        end
        default: ;
      endcase
    end
    if (ev_fault) begin
      cnt_nxt    = '0;
      good_nxt   = '0;
      locked_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      good_cnt     <= '0;
      width1       <= '0;
      width2       <= '0;
      width3       <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      err_seq      <= 1'b0;
      err_multi    <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      cnt          <= cnt_nxt;
      good_cnt     <= good_nxt;
      width1       <= width1_nxt;
      width2       <= width2_nxt;
      width3       <= width3_nxt;
      period       <= period_nxt;
      period_valid <= pv_nxt;
      locked       <= locked_nxt;
      err_seq      <= seq_nxt;
      err_multi    <= multi_nxt;
      err_timeout  <= to_nxt;
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_pwm_3_phase_rx.sv
// Randomised and directed bench for pwm_3_phase_rx against a cycle-level
// behavioural model driven from a two-cycle-delayed copy of the pin vector.
module tb_pwm_3_phase_rx;
  localparam int W        = 8;
  localparam int TIMEOUT  = 200;
  localparam int LOCK_ROT = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         pwm1, pwm2, pwm3;
  logic [1:0]   phase;
  logic [W-1:0] width1, width2, width3;
  logic [W+1:0] period;
  logic         period_valid, locked, err_seq, err_multi, err_timeout;

  pwm_3_phase_rx #(.W(W), .TIMEOUT(TIMEOUT), .LOCK_ROT(LOCK_ROT)) dut (
    .clk(clk), .rst(rst), .pwm1(pwm1), .pwm2(pwm2), .pwm3(pwm3),
    .phase(phase), .width1(width1), .width2(width2), .width3(width3),
    .period(period), .period_valid(period_valid), .locked(locked),
    .err_seq(err_seq), .err_multi(err_multi), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model state
  int pins, sh0, sh1;
  int m_ph, m_run, m_good, m_per;
  int m_w[4];
  bit m_lock, m_pv, m_seq, m_multi, m_to;
  int tp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    sh0 = 0; sh1 = 0;
    m_ph = 0; m_run = 0; m_good = 0; m_per = 0;
    for (int i = 0; i < 4; i++) m_w[i] = 0;
    m_lock = 0; m_pv = 0; m_seq = 0; m_multi = 0; m_to = 0;
  endtask

  task automatic model_fault();
    m_ph = 0; m_run = 0; m_good = 0; m_lock = 0;
  endtask

  task automatic model_step();
    int s, d, nx;
    s = sh1; sh1 = sh0; sh0 = pins;
    case (s)
      0: d = 0;
      1: d = 1;
      2: d = 2;
      4: d = 3;
      default: d = 4;
    endcase
    m_pv = 0; m_seq = 0; m_multi = 0; m_to = 0;
    if (m_ph == 0) begin
      if (d == 1) begin m_ph = 1; m_run = 1; end
      else if (d == 4) m_multi = 1;
    end else begin
      nx = (m_ph % 3) + 1;
      if (d == m_ph) begin
        if (m_run == TIMEOUT) begin m_to = 1; model_fault(); end
        else m_run++;
      end else if (d == nx) begin
        m_w[m_ph] = m_run;
        if (m_ph == 3) begin
          m_per = m_w[1] + m_w[2] + m_w[3];
          m_pv = 1;
          if (m_good < LOCK_ROT) m_good++;
          if (m_good == LOCK_ROT) m_lock = 1;
        end
        m_ph = nx; m_run = 1;
      end else if (d == 4) begin
        m_multi = 1; model_fault();
      end else if (d == 0) begin
        model_fault();
      end else begin
        m_seq = 1; model_fault();
      end
    end
  endtask

  task automatic compare_all();
    int nev;
    chk("phase", 32'(phase), 32'(m_ph));
    chk("width1", 32'(width1), 32'(m_w[1]));
    chk("width2", 32'(width2), 32'(m_w[2]));
    chk("width3", 32'(width3), 32'(m_w[3]));
    chk("period", 32'(period), 32'(m_per));
    chk("period_valid", 32'(period_valid), 32'(m_pv));
    chk("locked", 32'(locked), 32'(m_lock));
    chk("err_seq", 32'(err_seq), 32'(m_seq));
    chk("err_multi", 32'(err_multi), 32'(m_multi));
    chk("err_timeout", 32'(err_timeout), 32'(m_to));
    nev = int'(err_seq) + int'(err_multi) + int'(err_timeout) + int'(period_valid);
    chk("excl", 32'(nev <= 1), 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1 compare_all();
  endtask

  task automatic hold(input int v, input int n);
    pins = v;
    pwm1 = v[0]; pwm2 = v[1]; pwm3 = v[2];
    repeat (n) tick();
  endtask

  task automatic rotate(input int n);
    repeat (n) begin
      hold(1, 34); hold(2, 33); hold(4, 33);
    end
  endtask

  initial begin
    int r, v, mv;
    rst = 1'b1;
    pins = 0; pwm1 = 0; pwm2 = 0; pwm3 = 0;
    model_reset();
    repeat (3) tick();
    chk("rst_phase", 32'(phase), 32'd0);
    rst = 1'b0;
    hold(0, 3);

    // steady 34/33/33 pattern, then lock
    rotate(3);
    hold(1, 2);
    chk("d_width1", 32'(width1), 32'd34);
    chk("d_width2", 32'(width2), 32'd33);
    chk("d_width3", 32'(width3), 32'd33);
    chk("d_period", 32'(period), 32'd100);
    chk("d_locked", 32'(locked), 32'd1);

    // P1 then jump to P3, then stragglers held off until P1
    hold(1, 18); hold(4, 3);
    chk("seq_phase", 32'(phase), 32'd0);
    chk("seq_locked", 32'(locked), 32'd0);
    chk("seq_width1", 32'(width1), 32'd34);
    hold(4, 10); hold(2, 10);
    rotate(3);

    // overlap glitch during P2 while locked
    hold(1, 34); hold(2, 10); hold(6, 1); hold(2, 22); hold(4, 33);
    chk("multi_locked", 32'(locked), 32'd0);
    rotate(3);
    chk("relock", 32'(locked), 32'd1);

    // stall in P2
    hold(1, 34); hold(2, 260);
    chk("stall_phase", 32'(phase), 32'd0);

    // lines drop while locked, restart mid-pattern at P2
    rotate(3);
    hold(0, 10);
    chk("drop_locked", 32'(locked), 32'd0);
    hold(2, 33); hold(4, 33); hold(1, 34); hold(2, 5);
    chk("restart_w1", 32'(width1), 32'd34);

    // asynchronous reset mid-rotation
    hold(1, 34); hold(2, 10);
    #2 rst = 1'b1;
    #1;
    chk("arst_phase", 32'(phase), 32'd0);
    chk("arst_width1", 32'(width1), 32'd0);
    chk("arst_period", 32'(period), 32'd0);
    chk("arst_locked", 32'(locked), 32'd0);
    tick(); tick();
    rst = 1'b0;
    hold(2, 20); hold(4, 20);
    chk("arst_idle", 32'(phase), 32'd0);

    // randomized traffic
    tp = 1;
    repeat (200) begin
      r = $urandom_range(0, 11);
      if (r <= 6) begin
        hold(1 << (tp - 1), $urandom_range(1, 50));
        tp = (tp % 3) + 1;
      end else if (r == 7) begin
        mv = $urandom_range(0, 3);
        v = (mv == 0) ? 3 : (mv == 1) ? 5 : (mv == 2) ? 6 : 7;
        hold(v, $urandom_range(1, 3));
      end else if (r == 8) begin
        hold(0, $urandom_range(1, 10));
      end else if (r == 9) begin
        tp = (tp % 3) + 1;
        hold(1 << (tp - 1), $urandom_range(1, 20));
      end else if (r == 10) begin
        hold(1 << (tp - 1), $urandom_range(195, 215));
      end else begin
        hold(1 << (tp - 1), $urandom_range(1, 3));
        tp = (tp % 3) + 1;
      end
    end
    hold(0, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
